// File: rtl/cubic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cubic_seq_ctrl
// Description : Line sequencer for the cubic interpolation engine. Steps a
//               Q.8 source position, fetches four edge-clamped neighbours,
//               drives engine phase codes and weights {t,t^2,t^3}, and hands
//               each interpolated pixel out over a valid/ready port.
//               Optional: define CUBIC_SEQ_STALLCNT_EN to add stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module cubic_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   line_len,
    input  logic [ADDR_W+7:0]   step,
    input  logic [CNT_W-1:0]    num_out,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2:0]          eng_cc,
    output logic [23:0]         eng_x,
    input  logic [7:0]          out_data,
    output logic                res_valid,
    output logic [7:0]          res_data,
    input  logic                res_ready,
    output logic                busy,
    output logic                done
`ifdef CUBIC_SEQ_STALLCNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_FCAP  = 3'd4
    } state_t;

    localparam logic [2:0]        c_cc_hold  = 3'd7;
    localparam logic [2:0]        c_ph_last  = 3'd4;
    localparam logic [ADDR_W-1:0] c_addr_one = 1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = 1;

    // Sequencing state
    state_t              r_state_q, w_state_d;
    logic [2:0]          r_ph_q, w_ph_d;
    logic [ADDR_W+7:0]   r_pos_q, w_pos_d;
    logic [ADDR_W+7:0]   r_step_q, w_step_d;
    logic [ADDR_W-1:0]   r_len_q, w_len_d;
    logic [CNT_W-1:0]    r_num_q, w_num_d;
    logic [CNT_W-1:0]    r_k_q, w_k_d;

    // Registered outputs
    logic                r_mem_en_q, w_mem_en_d;
    logic [ADDR_W-1:0]   r_mem_addr_q, w_mem_addr_d;
    logic [2:0]          r_eng_cc_q, w_eng_cc_d;
    logic [23:0]         r_eng_x_q, w_eng_x_d;
    logic                r_res_valid_q, w_res_valid_d;
    logic [7:0]          r_res_data_q, w_res_data_d;
    logic                r_busy_q, w_busy_d;
    logic                r_done_q, w_done_d;

    // Combinational helpers
    logic                w_ok;
    logic                w_cap;
    logic [CNT_W-1:0]    w_k_inc;
    logic [ADDR_W+1:0]   w_bp1;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_t, w_t2, w_t3;
    logic [15:0]         w_sq, w_cu;

`ifdef CUBIC_SEQ_STALLCNT_EN
    logic [15:0]         r_stall_cnt_q, w_stall_cnt_d;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_ph_d    = r_ph_q;
        w_pos_d   = r_pos_q;
        w_step_d  = r_step_q;
        w_len_d   = r_len_q;
        w_num_d   = r_num_q;
        w_k_d     = r_k_q;
        w_done_d  = 1'b0;
        // A pending result must be gone (or leaving now) before a new one can be produced
        w_ok      = !r_res_valid_q || res_ready;
        w_k_inc   = r_k_q + c_cnt_one;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_len_d  = (line_len == '0) ? c_addr_one : line_len;
                    w_step_d = step;
                    w_num_d  = num_out;
                    w_pos_d  = '0;
                    w_k_d    = '0;
                    w_ph_d   = 3'd0;
                    if (num_out == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_ph_q == c_ph_last) begin
                    w_pos_d = r_pos_q + r_step_q;
                    w_k_d   = w_k_inc;
                    w_ph_d  = 3'd0;
                    if (!w_ok) begin
                        w_state_d = S_STALL;
                    end else if (w_k_inc < r_num_q) begin
                        w_state_d = S_RUN;
                    end else begin
                        w_state_d = S_FLUSH;
                    end
                end else begin
                    w_ph_d = r_ph_q + 3'd1;
                end
            end
            S_STALL: begin
                if (w_ok) begin
                    w_state_d = (r_k_q < r_num_q) ? S_RUN : S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_d = S_FCAP;
            end
            S_FCAP: begin
                w_state_d = S_IDLE;
                w_done_d  = 1'b1;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Neighbour index b-1+p, carried as (b+p) so the left edge stays unsigned
        w_bp1 = {2'b00, w_pos_d[ADDR_W+7:8]} + {{(ADDR_W-1){1'b0}}, w_ph_d};
        if (w_bp1 == '0) begin
            w_addr = '0;
        end else if (w_bp1 > {2'b00, w_len_d}) begin
            w_addr = w_len_d - c_addr_one;
        end else begin
            w_addr = w_bp1[ADDR_W-1:0] - c_addr_one;
        end

        w_t  = w_pos_d[7:0];
        w_sq = 16'(w_t) * 16'(w_t) + 16'd128;
        w_t2 = 8'(w_sq >> 8);
        w_cu = 16'(w_t2) * 16'(w_t) + 16'd128;
        w_t3 = 8'(w_cu >> 8);

        w_mem_en_d   = (w_state_d == S_RUN) && (w_ph_d != c_ph_last);
        w_mem_addr_d = w_mem_en_d ? w_addr : r_mem_addr_q;

        if (w_state_d == S_RUN) begin
            w_eng_cc_d = w_ph_d;
        end else if (w_state_d == S_FLUSH) begin
            w_eng_cc_d = 3'd0;
        end else begin
            w_eng_cc_d = c_cc_hold;
        end

        w_eng_x_d = r_eng_x_q;
        if ((w_state_d == S_RUN) && (w_ph_d == 3'd0)) begin
            w_eng_x_d = {w_t, w_t2, w_t3};
        end else if (w_state_d == S_FLUSH) begin
            w_eng_x_d = '0;
        end

        w_busy_d = (w_state_d != S_IDLE);

        // Engine output is valid the cycle after a result-producing phase 0
        w_cap = ((r_state_q == S_RUN) && (r_ph_q == 3'd1) && (r_k_q != '0)) ||
                (r_state_q == S_FCAP);
        w_res_data_d  = w_cap ? out_data : r_res_data_q;
        w_res_valid_d = w_cap || (r_res_valid_q && !res_ready);

`ifdef CUBIC_SEQ_STALLCNT_EN
        w_stall_cnt_d = r_stall_cnt_q;
        if ((r_state_q == S_IDLE) && start) begin
            w_stall_cnt_d = '0;
        end else if ((r_state_q == S_STALL) && (r_stall_cnt_q != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_ph_q        <= 3'd0;
            r_pos_q       <= '0;
            r_step_q      <= '0;
            r_len_q       <= c_addr_one;
            r_num_q       <= '0;
            r_k_q         <= '0;
            r_mem_en_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_eng_cc_q    <= c_cc_hold;
            r_eng_x_q     <= '0;
            r_res_valid_q <= 1'b0;
            r_res_data_q  <= '0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
`ifdef CUBIC_SEQ_STALLCNT_EN
            r_stall_cnt_q <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_ph_q        <= w_ph_d;
            r_pos_q       <= w_pos_d;
            r_step_q      <= w_step_d;
            r_len_q       <= w_len_d;
            r_num_q       <= w_num_d;
            r_k_q         <= w_k_d;
            r_mem_en_q    <= w_mem_en_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_eng_cc_q    <= w_eng_cc_d;
            r_eng_x_q     <= w_eng_x_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_data_q  <= w_res_data_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
`ifdef CUBIC_SEQ_STALLCNT_EN
            r_stall_cnt_q <= w_stall_cnt_d;
`endif
        end
    end

    assign mem_en    = r_mem_en_q;
    assign mem_addr  = r_mem_addr_q;
    assign eng_cc    = r_eng_cc_q;
    assign eng_x     = r_eng_x_q;
    assign res_valid = r_res_valid_q;
    assign res_data  = r_res_data_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;
`ifdef CUBIC_SEQ_STALLCNT_EN
    assign stall_cnt = r_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cubic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cubic_seq_ctrl
// Description : Self-checking bench for cubic_seq_ctrl with line memory and a
//               behavioural engine; expectations come from a per-sample model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cubic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  line_len;
    logic [15:0] step;
    logic [7:0]  num_out;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [2:0]  eng_cc;
    logic [23:0] eng_x;
    logic [7:0]  out_data = 8'h00;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
`ifdef CUBIC_SEQ_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cubic_seq_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_len  (line_len),
        .step      (step),
        .num_out   (num_out),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .eng_cc    (eng_cc),
        .eng_x     (eng_x),
        .out_data  (out_data),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
`ifdef CUBIC_SEQ_STALLCNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Line memory (1-cycle read latency) and behavioural engine
    logic [7:0]  mem [256];
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  pix [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [23:0] xl = 24'h0;

    function automatic logic [7:0] eng_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d,
                                          input logic [23:0] x);
        int s;
        s = a + 2 * b + 3 * c + 4 * d + x[23:16] + (x[15:8] ^ x[7:0]);
        return 8'(s);
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        if (eng_cc >= 3'd1 && eng_cc <= 3'd4) pix[int'(eng_cc) - 1] <= mem_rdata;
        if (eng_cc == 3'd4) xl <= eng_x;
        if (eng_cc == 3'd0) out_data <= eng_fn(pix[0], pix[1], pix[2], pix[3], xl);
    end

    function automatic logic [23:0] ref_x(input int t);
        int t2, t3;
        t2 = (t * t + 128) / 256;
        t3 = (t2 * t + 128) / 256;
        return {8'(t), 8'(t2), 8'(t3)};
    endfunction

    function automatic int ref_addr(input int b, input int i, input int len);
        int lp, a;
        lp = (len == 0) ? 1 : len;
        a  = b - 1 + i;
        if (a < 0) a = 0;
        if (a > lp - 1) a = lp - 1;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cc"},    32'(eng_cc),    32'd7);
        chk({tag, "_x"},     32'(eng_x),     32'd0);
        chk({tag, "_memen"}, 32'(mem_en),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_data"},  32'(res_data),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    // mode: 0 ready always, 1 random ready, 2 ready low 20 cycles after first result
    task automatic run_line(input int len, input int st, input int n, input int mode,
                            input bit timed, input bit restart);
        int          exp_addr[$];
        logic [23:0] exp_x[$];
        logic [7:0]  exp_res[$];
        int          reads, acc, rel, hold, busy7, exp_cc;
        bit          seen_done, prev_valid, first_seen, rise, exp_rise;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            int pos, b, t;
            int a[4];
            pos = (k * st) & 32'hFFFF;
            b   = pos >> 8;
            t   = pos & 255;
            for (int i = 0; i < 4; i++) begin
                a[i] = ref_addr(b, i, len);
                exp_addr.push_back(a[i]);
            end
            exp_x.push_back(ref_x(t));
            exp_res.push_back(eng_fn(mem[a[0]], mem[a[1]], mem[a[2]], mem[a[3]], ref_x(t)));
        end
        @(negedge clk);
        line_len  = 8'(len);
        step      = 16'(st);
        num_out   = 8'(n);
        start     = 1'b1;
        res_ready = 1'b1;
        reads = 0; acc = 0; rel = 0; hold = 0; busy7 = 0;
        seen_done = 1'b0; first_seen = 1'b0;
        prev_valid = res_valid;
        while (!(seen_done && acc == n) && rel < 3000) begin
            @(negedge clk);
            rel++;
            if (rel == 1) begin
                start    = 1'b0;
                line_len = 8'($urandom);
                step     = 16'($urandom);
                num_out  = 8'($urandom);
            end
            if (restart) start = (rel == 4);
            case (mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom);
                default: begin
                    if (res_valid && !first_seen) begin
                        first_seen = 1'b1;
                        hold = 20;
                    end
                    if (hold > 0) begin
                        res_ready = 1'b0;
                        hold--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
            endcase
            if (mem_en) begin
                chk("rd_cc", 32'(eng_cc), 32'(reads % 4));
                if (reads < 4 * n) begin
                    chk("rd_addr", 32'(mem_addr), 32'(exp_addr[reads]));
                    chk("rd_x", 32'(eng_x), 32'(exp_x[reads / 4]));
                end else begin
                    chk("rd_extra", 32'(reads), 32'(4 * n));
                end
                reads++;
            end else if (eng_cc == 3'd4 && reads > 0 && reads <= 4 * n) begin
                chk("ph4_x", 32'(eng_x), 32'(exp_x[(reads - 1) / 4]));
            end else if (eng_cc == 3'd0) begin
                chk("flush_reads", 32'(reads), 32'(4 * n));
                chk("flush_x", 32'(eng_x), 32'd0);
            end else begin
                chk("hold_cc", 32'(eng_cc), 32'd7);
            end
            if (busy && eng_cc == 3'd7) busy7++;
            if (timed && rel <= 5 * n + 3) begin
                if (rel <= 5 * n) exp_cc = (rel - 1) % 5;
                else if (rel == 5 * n + 1) exp_cc = 0;
                else exp_cc = 7;
                chk("seq_cc", 32'(eng_cc), 32'(exp_cc));
                rise     = res_valid && !prev_valid;
                exp_rise = (rel >= 8) && ((rel - 8) % 5 == 0) && ((rel - 8) / 5 < n);
                chk("valid_rise", 32'(rise), 32'(exp_rise));
                chk("done_time", 32'(done), 32'(rel == 5 * n + 3));
                chk("busy_time", 32'(busy), 32'(rel < 5 * n + 3));
            end
            if (res_valid && res_ready) begin
                if (acc < n) chk("res_data", 32'(res_data), 32'(exp_res[acc]));
                else chk("res_extra", 32'(acc), 32'(n));
                acc++;
            end
            if (done) begin
                chk("done_busy", 32'(busy), 32'd0);
                seen_done = 1'b1;
            end
            prev_valid = res_valid;
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("all_results", 32'(acc), 32'(n));
        chk("all_reads", 32'(reads), 32'(4 * n));
`ifdef CUBIC_SEQ_STALLCNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(busy7 - 1));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        line_len  = 8'd0;
        step      = 16'd0;
        num_out   = 8'd0;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Basic line: L=8, half-pixel step, 3 samples
        run_line(8, 'h080, 3, 0, 1'b1, 1'b0);

        // N=0: done pulse next cycle, nothing else moves
        @(negedge clk);
        start = 1'b1; num_out = 8'd0; line_len = 8'd8; step = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        chk("n0_done", 32'(done), 32'd1);
        chk("n0_cc", 32'(eng_cc), 32'd7);
        chk("n0_memen", 32'(mem_en), 32'd0);
        chk("n0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("n0_pulse", 32'(done), 32'd0);
        chk("n0_memen2", 32'(mem_en), 32'd0);

        // Edge clamps: b=7 at right edge, b beyond L, and L=0
        run_line(8, 'h700, 2, 0, 1'b1, 1'b0);
        run_line(8, 'h480, 3, 0, 1'b1, 1'b0);
        run_line(0, 'h1C0, 3, 0, 1'b1, 1'b0);

        // Backpressure
        run_line(8, 'h080, 3, 2, 1'b0, 1'b0);
        run_line(12, 'h0A3, 5, 2, 1'b0, 1'b0);
        run_line(20, 'h0C7, 6, 1, 1'b0, 1'b0);

        // Start pulse while busy must be ignored
        run_line(10, 'h0C0, 4, 0, 1'b1, 1'b1);

        // Position wrap-around
        run_line(16, 'hF080, 4, 0, 1'b1, 1'b0);

        // Reset during RUN phase 2, then a clean line
        @(negedge clk);
        line_len = 8'd8; step = 16'h0080; num_out = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_cc", 32'(eng_cc), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        run_line(8, 'h080, 3, 0, 1'b1, 1'b0);

        // Randomized lines
        for (int r = 0; r < 10; r++) begin
            int m;
            m = int'($urandom_range(0, 2));
            run_line(int'($urandom_range(0, 23)), int'($urandom_range(0, 'h3FF)),
                     int'($urandom_range(1, 6)), m, (m == 0), 1'b0);
        end

        @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
